// File: rtl/inst_fetch_queue.sv
// Purpose  : instruction-fetch front end; owns the fetch PC, issues sequential reads to
//            inst_sram and buffers returned {pc,inst} pairs in a DEPTH-entry queue for if_id.
// Latency  : issue in cycle N -> head visible in N+2 (N+1 with IFQ_BYPASS_EN); 1 fetch/cycle.
// Backpress: deq_ready_i=0 holds the head; fetches stop once queued + in-flight reach DEPTH,
//            so the returning read always has a free slot.
//
// Optional feature macro: IFQ_BYPASS_EN -- when the queue is empty, the returning read is
// presented on the dequeue port in its return cycle and skips storage if it is consumed.
//
// Ports
//   clk, rst                     clock / synchronous active-high reset
//   flush_i, flush_pc_i          redirect: drop queue and in-flight read, refetch from target
//   inst_sram_en/addr/rdata      fetch request and 1-cycle-latency read data
//   deq_valid_o/ready_i          head handshake towards if_id
//   deq_pc_o, deq_inst_o         head entry, forced to 0 when not valid
//   count_o                      number of entries held in storage
module inst_fetch_queue #(
   parameter int                 ADDR_W   = 32,
   parameter int                 INST_W   = 32,
   parameter int                 DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'hbfc00000)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush_i,
   input  logic [ADDR_W-1:0]           flush_pc_i,
   output logic                        inst_sram_en,
   output logic [ADDR_W-1:0]           inst_sram_addr,
   input  logic [INST_W-1:0]           inst_sram_rdata,
   output logic                        deq_valid_o,
   input  logic                        deq_ready_i,
   output logic [ADDR_W-1:0]           deq_pc_o,
   output logic [INST_W-1:0]           deq_inst_o,
   output logic [$clog2(DEPTH+1)-1:0]  count_o
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);

   // fetch state
   logic [ADDR_W-1:0] fetch_pc;
   logic              req_vld_q;
   logic [ADDR_W-1:0] req_pc_q;

   // queue storage
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   // handshake / control
   logic              head_ok;
   logic              fifo_vld;
   logic              byp;
   logic              pop;
   logic              fifo_pop;
   logic              push;
   logic              issue;
   logic [CNT_W:0]    occ;

   // Nothing is presented or fetched in a reset or redirect cycle.
   assign head_ok  = !rst && !flush_i;
   assign fifo_vld = (count != '0);

`ifdef IFQ_BYPASS_EN
   assign byp = head_ok && !fifo_vld && req_vld_q;
`else
   assign byp = 1'b0;
`endif

   assign deq_valid_o = head_ok && (fifo_vld || byp);
   assign pop         = deq_valid_o && deq_ready_i;
   // A bypassed entry is consumed straight from the read port, never from storage.
   assign fifo_pop    = pop && !byp;
   assign push        = head_ok && req_vld_q && !(byp && pop);

   // Credit check: stored entries plus the read in flight, minus what leaves this cycle,
   // must leave room for the read issued now. pop implies occ >= 1, so no underflow.
   assign occ   = {1'b0, count} + (CNT_W+1)'(req_vld_q) - (CNT_W+1)'(pop);
   assign issue = head_ok && (occ < (CNT_W+1)'(DEPTH));

   assign inst_sram_en   = issue;
   assign inst_sram_addr = fetch_pc;
   assign count_o        = count;

   always_comb begin
      deq_pc_o   = '0;
      deq_inst_o = '0;
      if (deq_valid_o) begin
         if (byp) begin
            deq_pc_o   = req_pc_q;
            deq_inst_o = inst_sram_rdata;
         end else begin
            deq_pc_o   = pc_mem[rd_ptr];
            deq_inst_o = inst_mem[rd_ptr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         req_vld_q <= 1'b0;
         req_pc_q  <= '0;
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
      end else if (flush_i) begin
         // The read returning this cycle is dropped along with everything queued.
         fetch_pc  <= flush_pc_i;
         req_vld_q <= 1'b0;
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
      end else begin
         req_vld_q <= issue;
         if (issue) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
            req_pc_q <= fetch_pc;
         end
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (fifo_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(fifo_pop);
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= req_pc_q;
         inst_mem[wr_ptr] <= inst_sram_rdata;
      end
   end

   // The credit rule must make a push into a full queue impossible.
   assert property (@(posedge clk) disable iff (rst)
      !(push && !fifo_pop && (count == CNT_W'(DEPTH))));

endmodule
